// File: rtl/flux_fire_scheduler_if.sv
// Token-write, back-pressure and fire-issue signals shared between the
// flux firing scheduler and whatever drives and consumes it.
interface flux_fire_scheduler_if #(
    parameter int FLUX        = 2,
    parameter int PORTS       = 2,
    parameter int PHASES      = 2,
    parameter int TAG_WIDTH   = ($clog2(FLUX) > 0 ? $clog2(FLUX) : 1),
    parameter int PHASE_WIDTH = ($clog2(PHASES) > 0 ? $clog2(PHASES) : 1)
);
    logic [PORTS-1:0]           in_write;
    logic [PORTS*TAG_WIDTH-1:0] in_tag;
    logic                       out_full;
    logic                       fire;
    logic [TAG_WIDTH-1:0]       fire_tag;
    logic [PORTS-1:0]           fire_pop;
    logic [PHASE_WIDTH-1:0]     fire_phase;
    logic [PORTS*FLUX-1:0]      port_full;
    logic                       err;

    // Producer/consumer side: drives token writes and back-pressure.
    modport master (
        output in_write, in_tag, out_full,
        input  fire, fire_tag, fire_pop, fire_phase, port_full, err
    );

    // Scheduler side.
    modport slave (
        input  in_write, in_tag, out_full,
        output fire, fire_tag, fire_pop, fire_phase, port_full, err
    );
endinterface

// File: rtl/flux_fire_scheduler.sv
// Firing scheduler for a shared multi-flux (PICK) actor. It mirrors the
// per-(port, flux) token occupancy of the tagged input FIFOs, tracks the
// CSDF phase of every flux and round-robins one firing per cycle among the
// fluxes that hold enough tokens for their current phase.
module flux_fire_scheduler #(
    parameter int FLUX = 2,
    parameter int PORTS = 2,
    parameter int DEPTH = 4,
    parameter int PHASES = 2,
    parameter logic [PHASES*PORTS-1:0] CONS_MASK = 4'b0111,
    parameter int TAG_WIDTH = ($clog2(FLUX) > 0 ? $clog2(FLUX) : 1)
) (
    input logic clk,
    input logic rst,
    flux_fire_scheduler_if.slave bus
);

    localparam int PHASE_WIDTH = ($clog2(PHASES) > 0 ? $clog2(PHASES) : 1);
    localparam int CNT_WIDTH   = $clog2(DEPTH + 1);
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = CNT_WIDTH'(DEPTH);
    localparam logic [PHASE_WIDTH-1:0] PHASE_MAX = PHASE_WIDTH'(PHASES - 1);

    logic [CNT_WIDTH-1:0]   count [PORTS][FLUX];
    logic [PHASE_WIDTH-1:0] phase [FLUX];
    logic [TAG_WIDTH-1:0]   ptr;

    logic                   fire_q;
    logic [TAG_WIDTH-1:0]   fire_tag_q;
    logic [PORTS-1:0]       fire_pop_q;
    logic [PHASE_WIDTH-1:0] fire_phase_q;
    logic                   err_q;

    logic [PORTS-1:0]       phase_mask [FLUX];
    logic [FLUX-1:0]        eligible;
    logic                   grant;
    logic [TAG_WIDTH-1:0]   grant_tag;
    logic [PORTS-1:0]       grant_mask;
    int                     idx;
    logic [TAG_WIDTH-1:0]   wr_tag [PORTS];
    logic [FLUX-1:0]        inc_hit [PORTS];
    logic [FLUX-1:0]        dec_hit [PORTS];
    logic                   wr_err;
    logic [PORTS*FLUX-1:0]  full_map;

    // A flux is ready when every port its current phase consumes holds a token.
    always_comb begin
        eligible = '0;
        for (int f = 0; f < FLUX; f++) begin
            phase_mask[f] = CONS_MASK[int'(phase[f])*PORTS +: PORTS];
            eligible[f] = ~bus.out_full;
            for (int p = 0; p < PORTS; p++) begin
                if (phase_mask[f][p] && count[p][f] == '0) begin
                    eligible[f] = 1'b0;
                end
            end
        end
    end

    // Round-robin pick starting after the last granted flux; scanning from
    // the far end lets the nearest eligible flux overwrite the others.
    always_comb begin
        grant = 1'b0;
        grant_tag = '0;
        idx = 0;
        for (int k = FLUX; k >= 1; k--) begin
            idx = (int'(ptr) + k) % FLUX;
            if (eligible[idx]) begin
                grant = 1'b1;
                grant_tag = TAG_WIDTH'(idx);
            end
        end
        grant_mask = phase_mask[grant_tag];
    end

    // Classify each incoming write as accepted or as a protocol error.
    always_comb begin
        wr_err = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            wr_tag[p] = bus.in_tag[p*TAG_WIDTH +: TAG_WIDTH];
            inc_hit[p] = '0;
            if (bus.in_write[p]) begin
                if (int'(wr_tag[p]) >= FLUX) begin
                    wr_err = 1'b1;
                end else if (count[p][wr_tag[p]] == CNT_MAX) begin
                    wr_err = 1'b1;
                end else begin
                    inc_hit[p][wr_tag[p]] = 1'b1;
                end
            end
        end
    end

    // Counters consumed by this cycle's grant, plus the registered full decode.
    always_comb begin
        full_map = '0;
        for (int p = 0; p < PORTS; p++) begin
            for (int f = 0; f < FLUX; f++) begin
                dec_hit[p][f] = grant && grant_mask[p] && (grant_tag == TAG_WIDTH'(f));
                full_map[p*FLUX + f] = (count[p][f] == CNT_MAX);
            end
        end
    end

    // Token counters, per-flux phase and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < PORTS; p++) begin
                for (int f = 0; f < FLUX; f++) begin
                    count[p][f] <= '0;
                end
            end
            for (int f = 0; f < FLUX; f++) begin
                phase[f] <= '0;
            end
            ptr <= TAG_WIDTH'(FLUX - 1);
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                for (int f = 0; f < FLUX; f++) begin
                    if (inc_hit[p][f] && !dec_hit[p][f]) begin
                        count[p][f] <= count[p][f] + CNT_WIDTH'(1);
                    end else if (dec_hit[p][f] && !inc_hit[p][f]) begin
                        count[p][f] <= count[p][f] - CNT_WIDTH'(1);
                    end
                end
            end
            for (int f = 0; f < FLUX; f++) begin
                if (grant && grant_tag == TAG_WIDTH'(f)) begin
                    phase[f] <= (phase[f] == PHASE_MAX) ? '0 : phase[f] + PHASE_WIDTH'(1);
                end
            end
            if (grant) begin
                ptr <= grant_tag;
            end
        end
    end

    // Registered fire descriptor and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            fire_q <= 1'b0;
            fire_tag_q <= '0;
            fire_pop_q <= '0;
            fire_phase_q <= '0;
            err_q <= 1'b0;
        end else begin
            fire_q <= grant;
            if (grant) begin
                fire_tag_q <= grant_tag;
                fire_pop_q <= grant_mask;
                fire_phase_q <= phase[grant_tag];
            end
            if (wr_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.fire       = fire_q;
    assign bus.fire_tag   = fire_tag_q;
    assign bus.fire_pop   = fire_pop_q;
    assign bus.fire_phase = fire_phase_q;
    assign bus.port_full  = full_map;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_flux_fire_scheduler.sv
// Scoreboard bench for flux_fire_scheduler: a token-count/phase model
// predicts every cycle's outputs, a monitor compares them after each edge,
// and directed sequences add hand-derived checks for the key scenarios.
module tb_flux_fire_scheduler;

    localparam int FLUX = 2;
    localparam int PORTS = 2;
    localparam int DEPTH = 4;
    localparam int PHASES = 2;
    localparam int TW = 1;
    localparam int PHW = 1;
    localparam int CMASK = 'b0111;

    typedef struct {
        int fire;
        int tag;
        int pop;
        int phase;
        int pfull;
        int err;
    } exp_t;

    logic clk;
    logic rst;
    int total;
    int bad;
    exp_t expq[$];

    int mCnt [PORTS][FLUX];
    int mPh [FLUX];
    int mPtr;
    int mFire, mTag, mPop, mPhase, mErr;

    flux_fire_scheduler_if #(.FLUX(FLUX), .PORTS(PORTS), .PHASES(PHASES), .TAG_WIDTH(TW)) bus ();

    flux_fire_scheduler #(
        .FLUX(FLUX), .PORTS(PORTS), .DEPTH(DEPTH), .PHASES(PHASES),
        .CONS_MASK(4'b0111), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int maskOf(int ph);
        return (CMASK >> (ph * PORTS)) & ((1 << PORTS) - 1);
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the reference model across the
    // coming edge and queue the outputs it predicts.
    task automatic applyStimulus(logic [PORTS-1:0] wr, logic [PORTS*TW-1:0] tg, logic ofull, logic rs);
        exp_t e;
        int g;
        int m;
        int t;
        int ready;
        int accTag [PORTS];
        @(negedge clk);
        bus.in_write = wr;
        bus.in_tag = tg;
        bus.out_full = ofull;
        rst = rs;
        if (rs) begin
            for (int p = 0; p < PORTS; p++)
                for (int f = 0; f < FLUX; f++) mCnt[p][f] = 0;
            for (int f = 0; f < FLUX; f++) mPh[f] = 0;
            mPtr = FLUX - 1;
            mFire = 0; mTag = 0; mPop = 0; mPhase = 0; mErr = 0;
        end else begin
            g = -1;
            if (!ofull) begin
                for (int k = 1; k <= FLUX; k++) begin
                    t = (mPtr + k) % FLUX;
                    m = maskOf(mPh[t]);
                    ready = 1;
                    for (int p = 0; p < PORTS; p++)
                        if (((m >> p) & 1) == 1 && mCnt[p][t] < 1) ready = 0;
                    if (g < 0 && ready == 1) g = t;
                end
            end
            for (int p = 0; p < PORTS; p++) begin
                accTag[p] = -1;
                if (wr[p]) begin
                    t = (int'(tg) >> (p * TW)) & ((1 << TW) - 1);
                    if (t >= FLUX || mCnt[p][t] >= DEPTH) mErr = 1;
                    else accTag[p] = t;
                end
            end
            if (g >= 0) begin
                m = maskOf(mPh[g]);
                for (int p = 0; p < PORTS; p++)
                    if (((m >> p) & 1) == 1) mCnt[p][g]--;
                mFire = 1; mTag = g; mPop = m; mPhase = mPh[g];
                mPh[g] = (mPh[g] + 1) % PHASES;
                mPtr = g;
            end else begin
                mFire = 0;
            end
            for (int p = 0; p < PORTS; p++)
                if (accTag[p] >= 0) mCnt[p][accTag[p]]++;
        end
        e.fire = mFire; e.tag = mTag; e.pop = mPop; e.phase = mPhase; e.err = mErr;
        e.pfull = 0;
        for (int p = 0; p < PORTS; p++)
            for (int f = 0; f < FLUX; f++)
                if (mCnt[p][f] == DEPTH) e.pfull |= (1 << (p * FLUX + f));
        expq.push_back(e);
    endtask

    // One cycle of stimulus followed by a direct check of the fire strobe.
    task automatic stepCheck(string name, logic [PORTS-1:0] wr, logic [PORTS*TW-1:0] tg,
                             logic ofull, logic rs, int expFire);
        applyStimulus(wr, tg, ofull, rs);
        @(posedge clk);
        #1;
        checkOutput(name, bus.fire, expFire);
    endtask

    // Idle until a fire appears (bounded) and check its descriptor.
    task automatic waitFire(string name, int budget, int tag, int pop, int ph);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            applyStimulus('0, '0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            if (bus.fire === 1'b1) begin
                seen = 1;
                checkOutput({name, "_tag"}, bus.fire_tag, tag);
                checkOutput({name, "_pop"}, bus.fire_pop, pop);
                checkOutput({name, "_phase"}, bus.fire_phase, ph);
            end
        end
        if (!seen) checkOutput({name, "_seen"}, 0, 1);
    endtask

    // Scoreboard monitor: compares every cycle's outputs with the model.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput("sb_fire", bus.fire, e.fire);
                checkOutput("sb_tag", bus.fire_tag, e.tag);
                checkOutput("sb_pop", bus.fire_pop, e.pop);
                checkOutput("sb_phase", bus.fire_phase, e.phase);
                checkOutput("sb_port_full", bus.port_full, e.pfull);
                checkOutput("sb_err", bus.err, e.err);
            end
        end
    end

    initial begin
        int rrTag [4] = '{0, 1, 0, 1};
        int rrPop [4] = '{3, 3, 1, 1};
        int rrPh [4] = '{0, 0, 1, 1};
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.in_write = '0;
        bus.in_tag = '0;
        bus.out_full = 1'b0;

        $display("[TB] reset check");
        repeat (3) applyStimulus('0, '0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("rst_fire", bus.fire, 0);
        checkOutput("rst_tag", bus.fire_tag, 0);
        checkOutput("rst_pop", bus.fire_pop, 0);
        checkOutput("rst_phase", bus.fire_phase, 0);
        checkOutput("rst_err", bus.err, 0);
        checkOutput("rst_port_full", bus.port_full, 0);

        $display("[TB] basic fire");
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b10, 2'b00, 1'b0, 1'b0);
        waitFire("basic0", 3, 0, 3, 0);
        stepCheck("basic_single", 2'b01, 2'b00, 1'b0, 1'b0, 0);
        waitFire("basic1", 3, 0, 1, 1);

        $display("[TB] round robin");
        applyStimulus('0, '0, 1'b0, 1'b1);
        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b11, 2'b11, 1'b1, 1'b0);
        applyStimulus(2'b11, 2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) waitFire("rr", 1, rrTag[i], rrPop[i], rrPh[i]);
        stepCheck("rr_done", 2'b00, 2'b00, 1'b0, 1'b0, 0);

        $display("[TB] back-pressure");
        stepCheck("bp_load", 2'b01, 2'b01, 1'b1, 1'b0, 0);
        stepCheck("bp_stall0", 2'b00, 2'b00, 1'b1, 1'b0, 0);
        stepCheck("bp_stall1", 2'b00, 2'b00, 1'b1, 1'b0, 0);
        waitFire("bp_release", 1, 1, 3, 0);

        $display("[TB] full and error");
        for (int i = 0; i < 4; i++) stepCheck("full_fill", 2'b10, 2'b10, 1'b0, 1'b0, 0);
        checkOutput("full_flag", bus.port_full, 4'b1000);
        checkOutput("full_err_clear", bus.err, 0);
        stepCheck("full_overflow", 2'b10, 2'b10, 1'b0, 1'b0, 0);
        checkOutput("overflow_err", bus.err, 1);
        checkOutput("overflow_full", bus.port_full, 4'b1000);
        stepCheck("err_hold0", 2'b00, 2'b00, 1'b0, 1'b0, 0);
        stepCheck("err_hold1", 2'b00, 2'b00, 1'b0, 1'b0, 0);
        checkOutput("err_sticky", bus.err, 1);

        $display("[TB] mid-operation reset");
        stepCheck("mid_load", 2'b01, 2'b01, 1'b0, 1'b0, 0);
        stepCheck("mid_fire0", 2'b01, 2'b01, 1'b0, 1'b0, 1);
        stepCheck("mid_fire1", 2'b01, 2'b01, 1'b0, 1'b0, 1);
        stepCheck("mid_reset", 2'b01, 2'b01, 1'b0, 1'b1, 0);
        checkOutput("mid_reset_err", bus.err, 0);
        checkOutput("mid_reset_full", bus.port_full, 0);
        applyStimulus(2'b11, 2'b11, 1'b0, 1'b0);
        waitFire("post_reset", 3, 1, 3, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(PORTS'($urandom), (PORTS*TW)'($urandom),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
        end

        @(posedge clk);
        #2;
        checkOutput("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
